// File: rtl/latency_credit_pkg.sv
// Shared definitions for the latency credit controller.
//   state_t       : controller mode (RUN, DRAIN, DONE)
//   credit_width(): bit width able to hold 0..depth, used for credits/outstanding
package latency_credit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay.sv
// Fixed-latency shift register.
//   clk, rst : clock, synchronous active-high reset (stages load INIT_VAL)
//   en       : shift enable
//   d        : input word
//   q        : d delayed by CYCLES enabled clocks
module delay #(
    parameter int               CYCLES   = 1,
    parameter int               WIDTH    = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [CYCLES];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its neighbour held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CYCLES; i++) stage[i] <= INIT_VAL;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < CYCLES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[CYCLES-1];

endmodule

// File: rtl/resp_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   wr_en    : push wr_data (ignored while full)
//   wr_data  : data to push
//   rd_en    : pop head (ignored while empty)
//   rd_data  : head entry, valid whenever empty is low
//   empty    : no entries
//   full     : DEPTH entries stored
module resp_fifo
    import latency_credit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = credit_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers define validity,
    // and leaving the array out of reset keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/latency_credit_ctrl.sv
// Credit-based flow controller for a fixed-latency, non-stallable datapath.
// Requests are launched only when a response-buffer slot is reserved; results
// are captured LATENCY cycles after launch and returned through a FWFT FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid/req_tag/req_ready : request handshake
//   dp_issue      : one-cycle launch strobe to the datapath
//   dp_rdata      : datapath result, sampled LATENCY cycles after dp_issue
//   resp_valid/resp_tag/resp_data/resp_ready : response handshake
//   drain_req     : level, stop accepting and wait for everything to return
//   drain_done    : drain complete (held until drain_req falls)
//   outstanding   : credits in use (in flight + buffered)
module latency_credit_ctrl
    import latency_credit_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int TAG_WIDTH  = 8,
    parameter int DATA_WIDTH = 64,
    parameter int BUF_DEPTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    input  logic [TAG_WIDTH-1:0]                 req_tag,
    output logic                                 req_ready,
    output logic                                 dp_issue,
    input  logic [DATA_WIDTH-1:0]                dp_rdata,
    output logic                                 resp_valid,
    output logic [TAG_WIDTH-1:0]                 resp_tag,
    output logic [DATA_WIDTH-1:0]                resp_data,
    input  logic                                 resp_ready,
    input  logic                                 drain_req,
    output logic                                 drain_done,
    output logic [credit_width(BUF_DEPTH)-1:0]   outstanding
);

    localparam int CW = credit_width(BUF_DEPTH);
    localparam int EW = TAG_WIDTH + DATA_WIDTH;

    state_t                 state;
    logic [CW-1:0]          credits;
    logic                   acc;
    logic                   pop;
    logic                   pipe_valid;
    logic [TAG_WIDTH-1:0]   pipe_tag;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [EW-1:0]          fifo_rdata;

    // drain_req gates readiness in the same cycle it rises, before the FSM moves.
    assign req_ready   = (state == RUN) && !drain_req && (credits != '0);
    assign acc         = req_valid & req_ready;
    assign dp_issue    = acc;
    assign resp_valid  = ~fifo_empty;
    assign pop         = resp_valid & resp_ready;
    assign outstanding = CW'(BUF_DEPTH) - credits;
    assign {resp_tag, resp_data} = fifo_rdata;

    // A credit is held from accept until the response is popped, so the sum of
    // in-flight and buffered entries never exceeds BUF_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CW'(BUF_DEPTH);
        end else if (acc && !pop && credits != '0) begin
            credits <= credits - 1'b1;
        end else if (pop && !acc && credits != CW'(BUF_DEPTH)) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            drain_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

    // Tracks which launch the datapath is returning this cycle.
    delay #(
        .CYCLES   (LATENCY),
        .WIDTH    (TAG_WIDTH + 1),
        .INIT_VAL ('0)
    ) u_track (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   ({acc, req_tag}),
        .q   ({pipe_valid, pipe_tag})
    );

    resp_fifo #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe_valid),
        .wr_data ({pipe_tag, dp_rdata}),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pipe_valid && fifo_full))
                else $error("response written while FIFO full");
        end
    end

endmodule
